// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, entry field
// layout and the base note period table (C5..B5 at a 50 MHz divider clock).
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int ENTRY_W  = 16;
  localparam int PERIOD_W = 17;
  localparam int DUR_W    = 10;

  localparam int NOTE_MSB = 15;
  localparam int NOTE_LSB = 12;
  localparam int OCT_MSB  = 11;
  localparam int OCT_LSB  = 10;
  localparam int DUR_MSB  = 9;
  localparam int DUR_LSB  = 0;

  // Notes at or above this code are rests.
  localparam logic [3:0] REST = 4'd12;

  localparam logic [PERIOD_W-1:0] NOTE_PERIOD [12] = '{
    17'd95557, 17'd90193, 17'd85131, 17'd80354, 17'd75843, 17'd71587,
    17'd67569, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619
  };

  // Divider period for a note and octave shift; rests map to silence.
  function automatic logic [PERIOD_W-1:0] note_to_period(input logic [3:0] note,
                                                         input logic [1:0] oct);
    logic [PERIOD_W-1:0] p;
    p = '0;
    if (note < REST) p = NOTE_PERIOD[note] >> oct;
    return p;
  endfunction

endpackage

// File: rtl/tone_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with a flush input. The head entry is
// presented combinationally on dout so a pop and a latch happen on one edge.
module tone_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  // Writes while full are dropped even if a pop happens in the same cycle.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // Pointer update; flush returns both pointers to the empty position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued note entries by driving the clock divider period. Entries are
// buffered in tone_fifo, decoded to a period, held for their duration in
// millisecond ticks, and then the next entry is loaded.
//
// state | meaning
// IDLE  | silent, waiting for enable and a queued entry
// LOAD  | popped entry latched; decode and load duration counters
// PLAY  | tone held; ms ticks counted while enabled, paused otherwise
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK   = CLK_HZ / 1000,
  parameter int DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ENTRY_W-1:0]  wdata,
  input  logic                enable,
  input  logic                clear,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                busy,
  output logic                note_done,
  output logic [PERIOD_W-1:0] maxcount
);

  localparam int             TW        = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK - 1);

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   entry_q, entry_d;
  logic [PERIOD_W-1:0]  maxcount_q, maxcount_d;
  logic [DUR_W-1:0]     remaining_q, remaining_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 note_done_q, note_done_d;
  logic                 overflow_q, overflow_d;
  logic                 pop;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PERIOD_W-1:0]  cur_period;
  logic [DUR_W-1:0]     cur_dur;

  tone_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .wr_en (wr_en),
    .din   (wdata),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cur_period = note_to_period(entry_q[NOTE_MSB:NOTE_LSB], entry_q[OCT_MSB:OCT_LSB]);
  assign cur_dur    = entry_q[DUR_MSB:DUR_LSB];

  // Next-state, counter and output decode; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    maxcount_d  = maxcount_q;
    remaining_d = remaining_q;
    tick_d      = tick_q;
    note_done_d = 1'b0;
    overflow_d  = overflow_q;
    pop         = 1'b0;

    if (wr_en && fifo_full) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        maxcount_d = '0;
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          entry_d = fifo_dout;
          state_d = LOAD;
        end
      end

      LOAD: begin
        remaining_d = cur_dur;
        tick_d      = '0;
        if (cur_dur == '0) begin
          // Zero-length entry: report it done, leave the divider untouched.
          note_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          maxcount_d = enable ? cur_period : '0;
          state_d    = PLAY;
        end
      end

      PLAY: begin
        if (!enable) begin
          maxcount_d = '0;
        end else begin
          maxcount_d = cur_period;
          if (tick_q == TICK_LAST) begin
            tick_d      = '0;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == DUR_W'(1)) begin
              note_done_d = 1'b1;
              if (!fifo_empty) begin
                // Back-to-back: the old period stays on through LOAD.
                pop     = 1'b1;
                entry_d = fifo_dout;
                state_d = LOAD;
              end else begin
                maxcount_d = '0;
                state_d    = IDLE;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        maxcount_d = '0;
        state_d    = IDLE;
      end
    endcase

    if (clear) begin
      state_d     = IDLE;
      maxcount_d  = '0;
      remaining_d = '0;
      tick_d      = '0;
      note_done_d = 1'b0;
      overflow_d  = 1'b0;
      pop         = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      maxcount_q  <= '0;
      remaining_q <= '0;
      tick_q      <= '0;
      note_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      maxcount_q  <= maxcount_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
      note_done_q <= note_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign busy      = (state_q != IDLE);
  assign overflow  = overflow_q;
  assign note_done = note_done_q;
  assign maxcount  = maxcount_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with TICK = 4. Inputs change and
// outputs are sampled on the falling edge.
module tb_tone_sequencer;

  localparam int TK = 4;
  localparam int DP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wdata = '0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        full, empty, overflow, busy, note_done;
  logic [16:0] maxcount;

  int tests = 0;
  int fails = 0;

  int unsigned base_tab [12] = '{95557, 90193, 85131, 80354, 75843, 71587,
                                 67569, 63776, 60197, 56818, 53629, 50619};

  tone_sequencer #(.CLK_HZ(4000), .TICK(TK), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .enable(enable),
    .clear(clear), .full(full), .empty(empty), .overflow(overflow),
    .busy(busy), .note_done(note_done), .maxcount(maxcount)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned exp_period(input logic [15:0] e);
    int unsigned n, o;
    n = e[15:12];
    o = e[11:10];
    if (n >= 12) return 0;
    return base_tab[n] / (32'd1 << o);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1; wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step(); step();
    tests++;
    if ({maxcount, busy, note_done, overflow, full, empty} !== {17'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: mc=%0d busy=%b nd=%b ovf=%b full=%b empty=%b, required 0 0 0 0 0 1",
               maxcount, busy, note_done, overflow, full, empty);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_note();
    enable = 1'b1;
    push(16'h9005);
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL single_empty: empty=%b required 0", empty); end
    step();
    tests++; if (maxcount !== 17'd0 || busy !== 1'b1) begin fails++; $display("FAIL single_load: mc=%0d busy=%b required 0 1", maxcount, busy); end
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if (maxcount !== 17'd56818 || note_done !== 1'b0) begin
        fails++; $display("FAIL single_play[%0d]: mc=%0d nd=%b required 56818 0", i, maxcount, note_done);
      end
    end
    step();
    tests++;
    if (note_done !== 1'b1 || maxcount !== 17'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_end: nd=%b mc=%0d busy=%b required 1 0 0", note_done, maxcount, busy);
    end
    step();
    tests++; if (note_done !== 1'b0) begin fails++; $display("FAIL single_nd_width: nd=%b required 0", note_done); end
  endtask

  task automatic test_octave_rest();
    enable = 1'b1;
    wr_en = 1'b1; wdata = 16'h0802; step();
    wdata = 16'hF001; step();
    wr_en = 1'b0;
    tests++; if (maxcount !== 17'd0) begin fails++; $display("FAIL oct_load: mc=%0d required 0", maxcount); end
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (maxcount !== 17'd23889) begin fails++; $display("FAIL oct_play[%0d]: mc=%0d required 23889", i, maxcount); end
    end
    step();
    tests++;
    if (maxcount !== 17'd23889 || note_done !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL oct_b2b_load: mc=%0d nd=%b busy=%b required 23889 1 1", maxcount, note_done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (maxcount !== 17'd0 || note_done !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL rest_play[%0d]: mc=%0d nd=%b busy=%b required 0 0 1", i, maxcount, note_done, busy);
      end
    end
    step();
    tests++;
    if (note_done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rest_end: nd=%b busy=%b required 1 0", note_done, busy);
    end
  endtask

  task automatic test_overflow();
    enable = 1'b0;
    for (int i = 0; i < DP; i++) push(16'h1001);
    tests++;
    if (full !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill: full=%b ovf=%b required 1 0", full, overflow); end
    push(16'h2001);
    tests++;
    if (full !== 1'b1 || overflow !== 1'b1 || empty !== 1'b0) begin
      fails++; $display("FAIL ovf_set: full=%b ovf=%b empty=%b required 1 1 0", full, overflow, empty);
    end
    wr_en = 1'b1; wdata = 16'h3001; clear = 1'b1;
    step();
    wr_en = 1'b0; clear = 1'b0;
    tests++;
    if (empty !== 1'b1 || overflow !== 1'b0 || full !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: empty=%b ovf=%b full=%b required 1 0 0", empty, overflow, full);
    end
  endtask

  task automatic test_pause();
    int ntone, nzero;
    bit done;
    enable = 1'b1;
    push(16'h4003);
    step();
    ntone = 0; nzero = 0; done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (maxcount !== 17'd75843) begin fails++; $display("FAIL pause_pre[%0d]: mc=%0d required 75843", i, maxcount); end
      else ntone++;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (maxcount !== 17'd0 || busy !== 1'b1) begin
        fails++; $display("FAIL pause_hold[%0d]: mc=%0d busy=%b required 0 1", i, maxcount, busy);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (note_done === 1'b1) done = 1;
      else if (maxcount === 17'd75843) ntone++;
      else nzero++;
    end
    tests++;
    if (!done || ntone != 12 || nzero != 0) begin
      fails++; $display("FAIL pause_total: done=%0d tone_cycles=%0d stray=%0d required 1 12 0", done, ntone, nzero);
    end
  endtask

  task automatic test_zero_duration();
    enable = 1'b1;
    wr_en = 1'b1; wdata = 16'h9001; step();
    wdata = 16'h2000; step();
    wr_en = 1'b0;
    repeat (4) step();
    tests++; if (maxcount !== 17'd56818) begin fails++; $display("FAIL zero_pre: mc=%0d required 56818", maxcount); end
    step();
    tests++;
    if (note_done !== 1'b1 || maxcount !== 17'd56818) begin
      fails++; $display("FAIL zero_first_done: nd=%b mc=%0d required 1 56818", note_done, maxcount);
    end
    step();
    tests++;
    if (note_done !== 1'b1 || maxcount !== 17'd56818 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_done: nd=%b mc=%0d busy=%b required 1 56818 0", note_done, maxcount, busy);
    end
    step();
    tests++;
    if (note_done !== 1'b0 || maxcount !== 17'd0) begin
      fails++; $display("FAIL zero_after: nd=%b mc=%0d required 0 0", note_done, maxcount);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    push(16'h7003);
    push(16'h5002);
    repeat (4) step();
    tests++; if (maxcount !== 17'd63776) begin fails++; $display("FAIL rstmid_pre: mc=%0d required 63776", maxcount); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({maxcount, busy, note_done, overflow, full, empty} !== {17'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rstmid_async: mc=%0d busy=%b nd=%b ovf=%b full=%b empty=%b, required 0 0 0 0 0 1",
               maxcount, busy, note_done, overflow, full, empty);
    end
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (maxcount !== 17'd0 || busy !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL rstmid_after: mc=%0d busy=%b empty=%b required 0 0 1", maxcount, busy, empty);
    end
  endtask

  task automatic test_fifo_random();
    int cnt;
    bit ovf, w, c;
    enable = 1'b0;
    pulse_clear();
    cnt = 0; ovf = 0;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom % 4) != 0;
      c = ($urandom % 16) == 0;
      wr_en = w; wdata = 16'(($urandom & 16'hFC00) | 16'd1); clear = c;
      step();
      wr_en = 1'b0; clear = 1'b0;
      if (c) begin cnt = 0; ovf = 0; end
      else if (w) begin
        if (cnt == DP) ovf = 1;
        else cnt++;
      end
      tests++;
      if (full !== (cnt == DP) || empty !== (cnt == 0) || overflow !== ovf) begin
        fails++; $display("FAIL fifo_rand[%0d]: full=%b empty=%b ovf=%b required %0b %0b %0b",
                          i, full, empty, overflow, cnt == DP, cnt == 0, ovf);
      end
    end
    pulse_clear();
  endtask

  task automatic test_random_play();
    logic [15:0] ent [$];
    int unsigned exp_mc [$];
    bit exp_nd [$];
    int k;
    logic [15:0] e;
    for (int r = 0; r < 5; r++) begin
      enable = 1'b0;
      pulse_clear();
      ent.delete(); exp_mc.delete(); exp_nd.delete();
      k = $urandom_range(1, DP);
      for (int j = 0; j < k; j++) begin
        e = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 10'($urandom_range(1, 3))};
        ent.push_back(e);
        push(e);
      end
      exp_mc.push_back(0); exp_nd.push_back(0);
      for (int j = 0; j < k; j++) begin
        for (int t = 0; t < int'(ent[j][9:0]) * TK; t++) begin
          exp_mc.push_back(exp_period(ent[j])); exp_nd.push_back(0);
        end
        exp_mc.push_back((j < k - 1) ? exp_period(ent[j]) : 0);
        exp_nd.push_back(1);
      end
      enable = 1'b1;
      for (int s = 0; s < exp_mc.size(); s++) begin
        step();
        tests++;
        if (maxcount !== 17'(exp_mc[s]) || note_done !== exp_nd[s]) begin
          fails++; $display("FAIL rand_play r%0d s%0d: mc=%0d nd=%b required %0d %0b",
                            r, s, maxcount, note_done, exp_mc[s], exp_nd[s]);
        end
      end
      tests++;
      if (busy !== 1'b0 || empty !== 1'b1) begin
        fails++; $display("FAIL rand_idle r%0d: busy=%b empty=%b required 0 1", r, busy, empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_octave_rest();
    test_overflow();
    test_pause();
    test_zero_duration();
    test_reset_mid();
    test_fifo_random();
    test_random_play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

- Plays a queue of note entries written by the MCU and drives the 17-bit `maxcount` input of the downstream clock divider that generates the speaker square wave.
- Each entry carries a note, an octave shift and a duration in milliseconds. The block buffers entries in a small FIFO, translates each note to a divider period, holds it for the programmed time, then advances to the next entry.
- `maxcount = 0` (divider silent) whenever nothing is playing.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency. Sets the millisecond tick only.
- `TICK`, default `CLK_HZ/1000`: clk cycles per millisecond tick.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1: system clock. One clock; all logic is rising-edge.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `wr_en`  in  1: push `wdata` into the FIFO this cycle.
- `wdata`  in  16: entry. [15:12] note, [11:10] octave shift, [9:0] duration in ms.
- `enable`  in  1: level. 1 = play, 0 = pause.
- `clear`  in  1: single-cycle flush command.
- `full`  out  1: FIFO full.
- `empty`  out  1: FIFO empty.
- `overflow`  out  1: sticky flag; set when a write is dropped.
- `busy`  out  1: state ≠ IDLE.
- `note_done`  out  1: one-cycle pulse when an entry finishes playing.
- `maxcount`  out  17: period to the clock divider; 0 = silent.

## Operation

Entry decode:
- Note 0–11 = C..B, using base table C5..B5 at 50 MHz: 95557, 90193, 85131, 80354, 75843, 71587, 67569, 63776, 60197, 56818, 53629, 50619.
- `maxcount = table[note] >> octave`.
- Note 12–15 = rest (`maxcount = 0` while the entry plays).

FIFO:
- Write while `full` is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
- Write and pop in the same cycle when not full: both take effect.

FSM states: IDLE, LOAD, PLAY.
- **IDLE**
  - `maxcount = 0`.
  - If `enable && !empty`: pop the head entry and go to LOAD.
- **LOAD**
  - Latch the popped entry and register the decoded `maxcount`.
  - Load `remaining = duration` and `tick_cnt = 0`.
  - If `duration == 0`: discard the entry, pulse `note_done`, go to IDLE; `maxcount` is unchanged from its prior value.
  - Otherwise go to PLAY.
- **PLAY**
  - If `enable`: `tick_cnt` counts 0..TICK-1. On wrap, `remaining` decrements.
  - When `remaining` reaches 0: pulse `note_done`.
    - If `enable && !empty`: pop and go to LOAD.
    - Otherwise go to IDLE.
  - If `!enable`: counters hold and `maxcount` is forced to 0 (pause). Playback resumes where it stopped when `enable` returns.
- **`clear`** (highest priority, any state): empty the FIFO, go to IDLE, `maxcount = 0`, clear `overflow`. A simultaneous `wr_en` is dropped without setting `overflow`.
- **Reset mid-operation**: identical effect to `clear`. The FIFO pointers reset as well.

## Timing

Reset values:
- `maxcount = 0`, `busy = 0`, `note_done = 0`, `overflow = 0`, `full = 0`, `empty = 1`, state = IDLE.

Latency:
- Write at edge N → `empty = 0` after N.
- IDLE pops at N+1 → LOAD.
- `maxcount` valid from edge N+2 (first PLAY cycle).

Duration and back-to-back entries:
- PLAY lasts exactly `duration × TICK` enabled cycles.
- Back-to-back entries insert one LOAD cycle, during which the previous `maxcount` holds. There is no silent gap.

Output registration:
- `note_done` is registered and asserted for exactly one cycle per entry.
- All outputs are registered except `full`, `empty` and `busy`, which decode directly from registered state.

## Structure

- Package `tone_pkg` holds:
  - `state_t` enum (IDLE, LOAD, PLAY)
  - entry field bit positions
  - 12-entry `NOTE_PERIOD` constant array of 17-bit values
  - `REST` note threshold (12)
- Sub-module `tone_fifo`: synchronous FIFO, DEPTH × 16.
  - Ports: `wr_en`, `rd_en`, `din`, `dout`, `full`, `empty`, `flush`.
  - Pointers are log2(DEPTH)+1 bits wide.
- The FSM, tick counter, duration counter and decode live in `tone_sequencer`.

## Test plan

- **Single note.** Reset, `enable = 1`, TICK = 4, write 0x9005 (A, octave 0, 5 ms) → `maxcount = 56818` for exactly 20 cycles starting 2 cycles after the write, then one `note_done` pulse, then `maxcount = 0` and `busy = 0`.
- **Octave and rest.** Write 0x0802 then 0xF001 → `maxcount = 23889` (95557 >> 2) for 8 cycles, 1 LOAD cycle, `maxcount = 0` for 4 cycles, two `note_done` pulses.
- **Overflow.** Fill 8 entries with `enable = 0`, then write a 9th → `full = 1`, `overflow = 1`, count stays 8. Pulse `clear` → `empty = 1`, `overflow = 0`.
- **Pause mid-note.** Drop `enable` for 10 cycles during a 3 ms note → `maxcount = 0` during the pause. Total enabled PLAY cycles is still 12.
- **Zero duration and reset.** A duration-0 entry yields `note_done` with no `maxcount` change. Assert `rst_n` low mid-PLAY → all outputs take reset values immediately, asynchronously.
